// File: rtl/wb_pkg.sv
// Shared constants for the writeback/commit stage: opcode_info bit map,
// load funct3 encodings and the commit-record width helper.
package wb_pkg;

  localparam int OI_LOAD  = 11;
  localparam int OI_STORE = 10;
  localparam int OI_LINK  = 9;
  localparam int F3_MSB   = 2;
  localparam int F3_LSB   = 0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Commit record layout: {pc, rd[4:0], wen, wdata, commit_info}
  function automatic int cm_rec_w(input int xlen, input int ci_w);
    return 2 * xlen + 6 + ci_w;
  endfunction

  localparam int CM_REC_W = cm_rec_w(64, 161);

endpackage

// File: rtl/wb_commit_stage_commit_fifo.sv
// Synchronous commit-record FIFO with occupancy count and valid/ready on
// both sides; DEPTH must be a power of two so pointers wrap naturally.
module commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign push_ready = (count_r != CNT_W'(DEPTH));
  assign pop_valid  = (count_r != {CNT_W{1'b0}});
  assign push_s     = push_valid & push_ready;
  assign pop_s      = pop_valid & pop_ready;
  assign pop_data   = mem_r[rd_ptr_r];

  // Storage is cleared on reset so the head reads as zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: forms the final writeback value, drives the RF
// write port, counts retirements and queues commit records for trace.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int CI_W  = 161
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_wen,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_memdata,
  input  logic [11:0]     in_opcode_info,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [CI_W-1:0] in_commit_info,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [63:0]     instret,
  output logic            cm_valid,
  input  logic            cm_ready,
  output logic [XLEN-1:0] cm_pc,
  output logic [4:0]      cm_rd,
  output logic            cm_wen,
  output logic [XLEN-1:0] cm_wdata,
  output logic [CI_W-1:0] cm_commit_info
);

  localparam int REC_W = cm_rec_w(XLEN, CI_W);

  logic             acc_s;
  logic             wen_masked_s;
  logic [XLEN-1:0]  link_s;
  logic [XLEN-1:0]  wdata_s;
  logic [REC_W-1:0] push_rec_s;
  logic [REC_W-1:0] head_rec_s;
  logic [63:0]      instret_r;
  logic             unused_oi_s;

  // Offset selects the byte lane; funct3 picks size and signedness
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] mem,
    input logic [2:0]      off,
    input logic [2:0]      f3
  );
    logic [XLEN-1:0] sh;
    sh = mem >> {off, 3'b000};
    case (f3)
      F3_LB:   load_extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LH:   load_extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:   load_extract = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_LD:   load_extract = sh;
      F3_LBU:  load_extract = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LHU:  load_extract = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LWU:  load_extract = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: load_extract = {XLEN{1'b0}};
    endcase
  endfunction

  assign unused_oi_s  = ^{in_opcode_info[OI_STORE], in_opcode_info[8:3]};
  assign acc_s        = in_valid & in_ready;
  assign wen_masked_s = in_reg_wen & (in_rd != 5'd0);
  assign link_s       = in_pc + {{(XLEN-3){1'b0}}, 3'd4};

  // Final writeback value selection
  always_comb begin
    wdata_s = in_alu_result;
    if (in_opcode_info[OI_LOAD]) begin
      wdata_s = load_extract(in_memdata, in_alu_result[2:0], in_opcode_info[F3_MSB:F3_LSB]);
    end else if (in_opcode_info[OI_LINK]) begin
      wdata_s = link_s;
    end else begin
      wdata_s = in_alu_result;
    end
  end

  assign rf_wen   = acc_s & wen_masked_s;
  assign rf_waddr = in_rd;
  assign rf_wdata = wdata_s;

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= 64'd0;
    end else if (acc_s) begin
      instret_r <= instret_r + 64'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret    = instret_r;
  assign push_rec_s = {in_pc, in_rd, wen_masked_s, wdata_s, in_commit_info};

  commit_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_rec_s),
    .pop_valid  (cm_valid),
    .pop_ready  (cm_ready),
    .pop_data   (head_rec_s)
  );

  assign {cm_pc, cm_rd, cm_wen, cm_wdata, cm_commit_info} = head_rec_s;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: stimulus queues expected RF and
// commit results; a negedge monitor compares them as the DUT presents them.
module tb_wb_commit_stage;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rd;
  logic         in_reg_wen;
  logic [63:0]  in_pc;
  logic [63:0]  in_memdata;
  logic [11:0]  in_opcode_info;
  logic [63:0]  in_alu_result;
  logic [160:0] in_commit_info;
  logic         rf_wen;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic [63:0]  instret;
  logic         cm_valid;
  logic         cm_ready;
  logic [63:0]  cm_pc;
  logic [4:0]   cm_rd;
  logic         cm_wen;
  logic [63:0]  cm_wdata;
  logic [160:0] cm_commit_info;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } rf_exp_t;

  typedef struct {
    logic [63:0]  pc;
    logic [4:0]   rd;
    logic         wen;
    logic [63:0]  wdata;
    logic [160:0] ci;
  } cm_exp_t;

  rf_exp_t     rf_q[$];
  cm_exp_t     cm_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret = 64'd0;

  wb_commit_stage #(.DEPTH(4), .XLEN(64), .CI_W(161)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen), .in_pc(in_pc),
    .in_memdata(in_memdata), .in_opcode_info(in_opcode_info),
    .in_alu_result(in_alu_result), .in_commit_info(in_commit_info),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .instret(instret), .cm_valid(cm_valid), .cm_ready(cm_ready),
    .cm_pc(cm_pc), .cm_rd(cm_rd), .cm_wen(cm_wen), .cm_wdata(cm_wdata),
    .cm_commit_info(cm_commit_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: RF port on every accept, commit port on every pop
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (rf_q.size() == 0) begin
          chk("rf_unexpected", 256'(1), 256'(0));
        end else begin
          rf_exp_t e;
          e = rf_q.pop_front();
          chk("rf_wen", 256'(rf_wen), 256'(e.wen));
          chk("rf_waddr", 256'(rf_waddr), 256'(e.waddr));
          chk("rf_wdata", 256'(rf_wdata), 256'(e.wdata));
        end
      end
      if (cm_valid && cm_ready) begin
        if (cm_q.size() == 0) begin
          chk("cm_unexpected", 256'(1), 256'(0));
        end else begin
          cm_exp_t c;
          c = cm_q.pop_front();
          chk("cm_pc", 256'(cm_pc), 256'(c.pc));
          chk("cm_rd", 256'(cm_rd), 256'(c.rd));
          chk("cm_wen", 256'(cm_wen), 256'(c.wen));
          chk("cm_wdata", 256'(cm_wdata), 256'(c.wdata));
          chk("cm_ci", 256'(cm_commit_info), 256'(c.ci));
        end
      end
    end
  end

  task automatic send(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                      input logic [63:0] mem, input logic [11:0] oi,
                      input logic [63:0] alu, input logic [63:0] exp_wdata);
    rf_exp_t e;
    cm_exp_t c;
    logic [160:0] ci;
    int n;
    bit ok;
    ci = 161'(pc) ^ (161'(alu) << 97);
    e.wen = wen && (rd != 5'd0);
    e.waddr = rd;
    e.wdata = exp_wdata;
    c.pc = pc;
    c.rd = rd;
    c.wen = wen && (rd != 5'd0);
    c.wdata = exp_wdata;
    c.ci = ci;
    rf_q.push_back(e);
    cm_q.push_back(c);
    in_pc = pc;
    in_rd = rd;
    in_reg_wen = wen;
    in_memdata = mem;
    in_opcode_info = oi;
    in_alu_result = alu;
    in_commit_info = ci;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) begin
      chk("send_timeout", 256'(0), 256'(1));
      void'(rf_q.pop_back());
      void'(cm_q.pop_back());
    end else begin
      exp_instret = exp_instret + 64'd1;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cm_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 256'(cm_q.size()), 256'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_rd = 5'd0;
    in_reg_wen = 1'b0;
    in_pc = 64'd0;
    in_memdata = 64'd0;
    in_opcode_info = 12'd0;
    in_alu_result = 64'd0;
    in_commit_info = 161'd0;
    cm_ready = 1'b1;
    #12;
    chk("rst_cm_valid", 256'(cm_valid), 256'(0));
    chk("rst_cm_wdata", 256'(cm_wdata), 256'(0));
    chk("rst_instret", 256'(instret), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // Basic ALU writeback
    send(64'h1000, 5'd5, 1'b1, 64'd0, 12'h000, 64'h1234, 64'h1234);
    chk("t1_cm_valid", 256'(cm_valid), 256'(1));
    chk("t1_instret", 256'(instret), 256'(1));
    drain();

    // Loads
    send(64'h1004, 5'd6, 1'b1, 64'h0000_0000_80FF_0000, 12'h800, 64'h3, 64'hFFFF_FFFF_FFFF_FF80);
    send(64'h1008, 5'd7, 1'b1, 64'h0000_0000_80FF_0000, 12'h804, 64'h3, 64'h80);
    send(64'h100C, 5'd8, 1'b1, 64'h0000_0000_80FF_0000, 12'h801, 64'h2, 64'hFFFF_FFFF_FFFF_80FF);
    send(64'h1010, 5'd9, 1'b1, 64'h1122_3344_5566_7788, 12'h803, 64'h0, 64'h1122_3344_5566_7788);
    send(64'h1014, 5'd10, 1'b1, 64'h89AB_CDEF_0000_0000, 12'h806, 64'h4, 64'h89AB_CDEF);
    send(64'h1018, 5'd11, 1'b1, 64'h89AB_CDEF_0000_0000, 12'h802, 64'h4, 64'hFFFF_FFFF_89AB_CDEF);
    send(64'h101C, 5'd12, 1'b1, 64'h89AB_CDEF_0000_0000, 12'h807, 64'h4, 64'h0);
    // Link, including wrap
    send(64'h8000_0000, 5'd1, 1'b1, 64'd0, 12'h200, 64'h55, 64'h8000_0004);
    send(64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1'b1, 64'd0, 12'h200, 64'h55, 64'h0);
    // rd == 0 still commits
    send(64'h2000, 5'd0, 1'b1, 64'd0, 12'h000, 64'hABCD, 64'hABCD);
    drain();
    chk("instret_mid", 256'(instret), 256'(exp_instret));

    // Back-pressure: four fill the FIFO, fifth waits
    cm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(64'h3000 + 64'(i * 4), 5'(i + 1), 1'b1, 64'd0, 12'h000, 64'(100 + i), 64'(100 + i));
    end
    chk("full_in_ready", 256'(in_ready), 256'(0));
    chk("full_hold_wdata", 256'(cm_wdata), 256'(100));
    repeat (2) @(posedge clk);
    #1;
    chk("full_hold_pc", 256'(cm_pc), 256'(64'h3000));
    cm_ready = 1'b1;
    send(64'h3010, 5'd5, 1'b1, 64'd0, 12'h000, 64'd104, 64'd104);
    drain();
    chk("instret_bp", 256'(instret), 256'(exp_instret));

    // Simultaneous push/pop at count 2, then reset mid-drain
    cm_ready = 1'b0;
    send(64'h4000, 5'd3, 1'b1, 64'd0, 12'h000, 64'd200, 64'd200);
    send(64'h4004, 5'd4, 1'b1, 64'd0, 12'h000, 64'd201, 64'd201);
    cm_ready = 1'b1;
    send(64'h4008, 5'd5, 1'b1, 64'd0, 12'h000, 64'd202, 64'd202);
    chk("pushpop_count", 256'(dut.u_fifo.count_r), 256'(2));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cm_valid", 256'(cm_valid), 256'(0));
    chk("arst_instret", 256'(instret), 256'(0));
    chk("arst_cm_wdata", 256'(cm_wdata), 256'(0));
    cm_q.delete();
    rf_q.delete();
    exp_instret = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'h5000, 5'd2, 1'b1, 64'd0, 12'h000, 64'h77, 64'h77);
    drain();
    chk("instret_post_rst", 256'(instret), 256'(exp_instret));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
Writeback-side consumer of the M/W pipeline register. It accepts one retiring instruction per cycle over a valid/ready handshake and forms the final writeback value: load-data extraction, link value or ALU result. It drives the integer register-file write port, counts retired instructions, and buffers commit records in a small FIFO that drains to the difftest/trace consumer, back-pressuring the pipeline when the FIFO is full.

Parameters:
DEPTH, 4, commit FIFO entries (power of two, at least 2)
XLEN, 64, datapath width
CI_W, 161, commit_info width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  M/W register holds a retiring instruction
in_ready  out  1  stage can accept this cycle
in_rd  in  5  destination register
in_reg_wen  in  1  instruction writes rd
in_pc  in  XLEN  instruction PC
in_memdata  in  XLEN  raw aligned doubleword from memory
in_opcode_info  in  12  decoded class bits (see package)
in_alu_result  in  XLEN  ALU result, or effective address for loads
in_commit_info  in  CI_W  opaque trace payload
rf_wen  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
instret  out  64  retired-instruction count
cm_valid  out  1  commit record available
cm_ready  in  1  consumer takes record
cm_pc  out  XLEN  committed PC
cm_rd  out  5  committed rd
cm_wen  out  1  committed write enable after rd==0 masking
cm_wdata  out  XLEN  committed write data
cm_commit_info  out  CI_W  payload pass-through

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: FIFO empty, so cm_valid=0 and cm_* data=0. instret=0. in_ready=1 after reset release.
- Accept: acc = in_valid & in_ready. in_ready = (count != DEPTH). in_ready is a function of registered count only; a pop in the same cycle does not raise in_ready.
- Writeback data:
  - opcode_info[OI_LOAD]: byte offset = alu_result[2:0]; shift memdata right by 8*offset.
  - Size and sign come from opcode_info[2:0] (funct3):
    - 000 LB: sign-extend bits 7:0
    - 001 LH: sign-extend bits 15:0
    - 010 LW: sign-extend bits 31:0
    - 011 LD: full 64 bits
    - 100 LBU, 101 LHU, 110 LWU: zero-extend
    - 111: data 0
  - opcode_info[OI_LINK] (JAL/JALR): pc+4, modulo 2^64.
  - Otherwise: alu_result.
- RF write is combinational from the accepted input:
  - rf_wen = acc & in_reg_wen & (in_rd != 0)
  - rf_waddr = in_rd
  - rf_wdata = wdata
  - The write lands at the same clk edge; no extra latency.
- instret increments by 1 on every acc and wraps at 2^64.
- FIFO:
  - Push on acc of {pc, rd, wen masked, wdata, commit_info}.
  - Pop on cm_valid & cm_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - cm_* show the head entry combinationally; cm_valid = (count != 0).
  - Data is held stable while cm_valid=1 and cm_ready=0.
- Pop when empty is ignored. No push occurs when full, because in_ready=0.
- Reset asserted mid-operation discards all FIFO contents immediately; in-flight records are lost by design.

Decomposition:
- Package wb_pkg holds:
  - opcode_info bit indices: OI_LOAD=11, OI_STORE=10, OI_LINK=9; funct3 field [2:0]
  - load funct3 localparams
  - commit-record struct width constant
- One sub-module, commit_fifo: a parameterized synchronous FIFO with count, async active-low reset, and valid/ready on both sides.
- Load extraction stays inline as a function.

Test Plan:
- Reset, then in_valid=1, reg_wen=1, rd=5, alu_result=0x1234, not load -> same cycle rf_wen=1, waddr=5, wdata=0x1234; next cycle cm_valid=1 with cm_wdata=0x1234 and instret=1.
- Load LB, alu_result=0x...03, memdata=0x00000000_80FF0000 -> byte 0x80 -> rf_wdata=0xFFFFFFFF_FFFFFF80; same data with LBU -> 0x80.
- Link, pc=0x8000_0000 -> rf_wdata=0x8000_0004; pc=0xFFFF_FFFF_FFFF_FFFC -> 0x0.
- rd=0 with reg_wen=1 -> rf_wen=0, cm_wen=0; the record is still committed and instret still increments.
- Hold cm_ready=0 and push 5 consecutive -> 4 accepted, then in_ready=0; on cm_ready=1, records drain in order.
- Simultaneous push/pop at count=2 -> count stays 2. Assert rst_n=0 mid-drain -> cm_valid=0 and instret=0 immediately, without waiting for a clk edge.
